// File: rtl/spi_master_engine_if.sv
// Host/slave-facing bus of the SPI master engine. The engine uses the slave
// modport; a host or bench uses the master modport.
interface spi_master_engine_if #(
  parameter int DATA_W = 8
);
  // Handshake: START is only looked at while BUSY=0; the posedge that sees it
  // high latches TX_DATA/CPOL/CPHA and raises BUSY. DONE pulses for one cycle
  // as BUSY falls, and RX_DATA is valid from that cycle until the next DONE.
  logic              START;
  logic [DATA_W-1:0] TX_DATA;
  logic              CPOL;
  logic              CPHA;
  logic              MISO;
  logic              MOSI;
  logic              SCLK;
  logic              SS_N;
  logic [DATA_W-1:0] RX_DATA;
  logic              BUSY;
  logic              DONE;

  modport slave (
    input  START, TX_DATA, CPOL, CPHA, MISO,
    output MOSI, SCLK, SS_N, RX_DATA, BUSY, DONE
  );

  modport master (
    output START, TX_DATA, CPOL, CPHA, MISO,
    input  MOSI, SCLK, SS_N, RX_DATA, BUSY, DONE
  );
endinterface

// File: rtl/spi_master_engine.sv
// Full-duplex SPI master: one DATA_W-bit frame per accepted START in any
// CPOL/CPHA mode, edge n of SCLK landing exactly n*DIV cycles after SS_N falls.
module spi_master_engine #(
  parameter int DIV    = 2,
  parameter int DATA_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  spi_master_engine_if.slave     bus,
  output logic [1:0]             dbg_state_o
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [7:0]    DIV_LAST  = 8'(DIV - 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic [EW-1:0]     edge_n;
  logic              sample_edge;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // With CPHA=0 the odd (leading) edges sample; with CPHA=1 the even ones do.
  assign tick        = (div_q == DIV_LAST);
  assign edge_n      = edge_q + EW'(1);
  assign sample_edge = cpha_q ? ~edge_n[0] : edge_n[0];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = bus.CPOL;
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        edge_d = '0;
        if (bus.START) begin
          tx_d    = bus.TX_DATA;
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = bus.CPHA ? 1'b0 : bus.TX_DATA[DATA_W-1];
          state_d = SETUP;
        end
      end

      SETUP, SHIFT: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          edge_d = edge_n;
          sclk_d = ~sclk_q;
          if (sample_edge) begin
            rx_d = {rx_q[DATA_W-2:0], bus.MISO};
          end else if (cpha_q) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end else if (edge_n != LAST_EDGE) begin
            // MSB went out at SS_N fall, so each shift exposes the next bit.
            mosi_d = tx_q[DATA_W-2];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          state_d = (edge_n == LAST_EDGE) ? HOLD : SHIFT;
        end
      end

      HOLD: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          ss_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_q;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.MOSI    = mosi_q;
  assign bus.SCLK    = sclk_q;
  assign bus.SS_N    = ss_n_q;
  assign bus.RX_DATA = rx_data_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: three instances (DIV=2, 3, 1) share
// one host driver, selected by sel; loopback or a mode-3 slave feeds MISO.
module tb_spi_master_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_in = 8'h00;
  logic       cpol_in = 1'b0;
  logic       cpha_in = 1'b0;
  int         sel = 0;
  logic       slave_en = 1'b0;
  logic       miso_slv = 1'b0;
  logic [7:0] slv_pat = 8'h3C;
  logic [7:0] slv_rx = 8'h00;
  logic [2:0] slv_idx = 3'd7;
  logic       sclk_prev = 1'b0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic       mosi_m, sclk_m, ss_n_m, busy_m, done_m;
  logic [7:0] rx_m;
  logic [1:0] dbg0, dbg1, dbg2, dbg_m;

  always #5 clk = ~clk;

  spi_master_engine_if #(.DATA_W(8)) if0 ();
  spi_master_engine_if #(.DATA_W(8)) if1 ();
  spi_master_engine_if #(.DATA_W(8)) if2 ();

  spi_master_engine #(.DIV(2), .DATA_W(8)) u_div2 (.CLK(clk), .RST_N(rst_n), .bus(if0), .dbg_state_o(dbg0));
  spi_master_engine #(.DIV(3), .DATA_W(8)) u_div3 (.CLK(clk), .RST_N(rst_n), .bus(if1), .dbg_state_o(dbg1));
  spi_master_engine #(.DIV(1), .DATA_W(8)) u_div1 (.CLK(clk), .RST_N(rst_n), .bus(if2), .dbg_state_o(dbg2));

  assign if0.START = start && (sel == 0);
  assign if1.START = start && (sel == 1);
  assign if2.START = start && (sel == 2);
  assign if0.TX_DATA = tx_in;
  assign if1.TX_DATA = tx_in;
  assign if2.TX_DATA = tx_in;
  assign if0.CPOL = cpol_in;
  assign if1.CPOL = cpol_in;
  assign if2.CPOL = cpol_in;
  assign if0.CPHA = cpha_in;
  assign if1.CPHA = cpha_in;
  assign if2.CPHA = cpha_in;
  assign if0.MISO = if0.MOSI;
  assign if1.MISO = slave_en ? miso_slv : if1.MOSI;
  assign if2.MISO = if2.MOSI;

  assign mosi_m = (sel == 0) ? if0.MOSI    : (sel == 1) ? if1.MOSI    : if2.MOSI;
  assign sclk_m = (sel == 0) ? if0.SCLK    : (sel == 1) ? if1.SCLK    : if2.SCLK;
  assign ss_n_m = (sel == 0) ? if0.SS_N    : (sel == 1) ? if1.SS_N    : if2.SS_N;
  assign busy_m = (sel == 0) ? if0.BUSY    : (sel == 1) ? if1.BUSY    : if2.BUSY;
  assign done_m = (sel == 0) ? if0.DONE    : (sel == 1) ? if1.DONE    : if2.DONE;
  assign rx_m   = (sel == 0) ? if0.RX_DATA : (sel == 1) ? if1.RX_DATA : if2.RX_DATA;
  assign dbg_m  = (sel == 0) ? dbg0        : (sel == 1) ? dbg1        : dbg2;

  // Mode-3 slave: shifts slv_pat out after falling SCLK, captures MOSI after rising SCLK.
  always @(negedge clk) begin
    sclk_prev <= sclk_m;
    if (done_m) done_cnt <= done_cnt + 1;
    if (ss_n_m) begin
      slv_idx <= 3'd7;
    end else if (slave_en) begin
      if (sclk_prev && !sclk_m) begin
        miso_slv <= slv_pat[slv_idx];
        slv_idx  <= slv_idx - 3'd1;
      end
      if (!sclk_prev && sclk_m) slv_rx <= {slv_rx[6:0], mosi_m};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present START at a negedge; on return we sit at the negedge after acceptance.
  task automatic start_frame(input string tag, input logic [7:0] tx, input logic pol,
                             input logic pha, input bit hold);
    @(negedge clk);
    start   = 1'b1;
    tx_in   = tx;
    cpol_in = pol;
    cpha_in = pha;
    @(negedge clk);
    check({tag, "_ss_fall"}, ss_n_m, 1'b0);
    if (!hold) start = 1'b0;
  endtask

  // Count cycles to DONE; inj>=0 pulses a stray START with TX=0xFF at that cycle.
  task automatic wait_frame(input int inj, output int cyc, output int rises, output int drops);
    logic prev;
    cyc = 0; rises = 0; drops = 0;
    prev = sclk_m;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sclk_m && !prev) rises++;
      prev = sclk_m;
      if (cyc == inj) begin
        start = 1'b1;
        tx_in = 8'hFF;
      end else if (cyc == inj + 1) begin
        start = 1'b0;
      end
      if (done_m) break;
      if (!busy_m) drops++;
    end
  endtask

  int cyc, rises, drops, d0;

  initial begin
    // Reset state on every instance
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_sclk", sclk_m, 1'b0);
      check("rst_mosi", mosi_m, 1'b0);
      check("rst_ss_n", ss_n_m, 1'b1);
      check("rst_busy", busy_m, 1'b0);
      check("rst_done", done_m, 1'b0);
      check("rst_rx", rx_m, 8'h00);
      check("rst_state", dbg_m, 2'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: DIV=2 mode 0 loopback 0xA5
    start_frame("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1_busy", busy_m, 1'b1);
    check("t1_mosi_msb", mosi_m, 1'b1);
    wait_frame(-1, cyc, rises, drops);
    check("t1_done_cyc", cyc, 34);
    check("t1_rises", rises, 8);
    check("t1_busy_done", busy_m, 1'b0);
    check("t1_ss_done", ss_n_m, 1'b1);
    check("t1_rx", rx_m, 8'hA5);
    @(negedge clk);
    check("t1_done_pulse", done_m, 1'b0);

    // 2: DIV=3 mode 3 against the slave model
    sel = 1;
    slave_en = 1'b1;
    slv_pat = 8'h3C;
    cpol_in = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_sclk_idle_pre", sclk_m, 1'b1);
    start_frame("t2", 8'hC3, 1'b1, 1'b1, 1'b0);
    check("t2_mosi_setup", mosi_m, 1'b0);
    wait_frame(-1, cyc, rises, drops);
    check("t2_done_cyc", cyc, 51);
    check("t2_rises", rises, 8);
    check("t2_sclk_idle_post", sclk_m, 1'b1);
    check("t2_slave_rx", slv_rx, 8'hC3);
    check("t2_rx", rx_m, 8'h3C);
    slave_en = 1'b0;

    // 3: DIV=1 modes 1 and 2 loopback 0x81
    sel = 2;
    start_frame("t3m1", 8'h81, 1'b0, 1'b1, 1'b0);
    wait_frame(-1, cyc, rises, drops);
    check("t3m1_done_cyc", cyc, 17);
    check("t3m1_rises", rises, 8);
    check("t3m1_rx", rx_m, 8'h81);
    start_frame("t3m2", 8'h7E, 1'b1, 1'b0, 1'b0);
    wait_frame(-1, cyc, rises, drops);
    check("t3m2_done_cyc", cyc, 17);
    check("t3m2_rises", rises, 8);
    check("t3m2_rx", rx_m, 8'h7E);
    start_frame("t3m2b", 8'h81, 1'b1, 1'b0, 1'b0);
    wait_frame(-1, cyc, rises, drops);
    check("t3m2b_rx", rx_m, 8'h81);

    // 4: stray START with TX=0xFF mid-frame of 0x12
    sel = 0;
    d0 = done_cnt;
    start_frame("t4", 8'h12, 1'b0, 1'b0, 1'b0);
    wait_frame(10, cyc, rises, drops);
    check("t4_done_cyc", cyc, 34);
    check("t4_busy_drops", drops, 0);
    check("t4_rx", rx_m, 8'h12);
    repeat (40) @(negedge clk);
    check("t4_single_done", done_cnt - d0, 1);
    check("t4_idle_after", busy_m, 1'b0);

    // 5: START held across DONE, 0x55 then 0xAA
    start_frame("t5a", 8'h55, 1'b0, 1'b0, 1'b1);
    wait_frame(-1, cyc, rises, drops);
    check("t5a_done_cyc", cyc, 34);
    check("t5a_rx", rx_m, 8'h55);
    check("t5_ss_hi", ss_n_m, 1'b1);
    tx_in = 8'hAA;
    @(negedge clk);
    check("t5_ss_gap", ss_n_m, 1'b0);
    check("t5_busy_gap", busy_m, 1'b1);
    start = 1'b0;
    wait_frame(-1, cyc, rises, drops);
    check("t5b_done_cyc", cyc, 34);
    check("t5b_rx", rx_m, 8'hAA);

    // 6: reset right after edge 7, then a clean frame
    start_frame("t6", 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_ss_n", ss_n_m, 1'b1);
    check("t6_sclk", sclk_m, 1'b0);
    check("t6_busy", busy_m, 1'b0);
    check("t6_rx", rx_m, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    start_frame("t6b", 8'h5A, 1'b0, 1'b0, 1'b0);
    wait_frame(-1, cyc, rises, drops);
    check("t6b_done_cyc", cyc, 34);
    check("t6b_rises", rises, 8);
    check("t6b_rx", rx_m, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
SPI master serialiser that sits directly upstream of the AT89C51IC2-style SPI peripheral model. It drives SCLK, MOSI and a slave select, samples MISO, and returns the received byte.
A host loads a byte and pulses START. The engine runs one full-duplex 8-bit frame in any of the four CPOL/CPHA modes, then reports completion with a one-cycle DONE pulse.

Parameters:
DIV, 2, CLK cycles per SCLK half-period; legal range 1..255.
DATA_W, 8, frame length in bits, MSB first; the bench uses only 8.

Ports:
CLK  input  1  system clock; all logic on posedge.
RST_N  input  1  asynchronous, active-low reset.
START  input  1  frame request; sampled only in IDLE.
TX_DATA  input  DATA_W  byte to transmit; latched when START is accepted.
CPOL  input  1  SCLK idle level; latched when START is accepted.
CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched when START is accepted.
MISO  input  1  serial data from the slave.
MOSI  output  1  serial data to the slave.
SCLK  output  1  serial clock.
SS_N  output  1  active-low slave select.
RX_DATA  output  DATA_W  last completed received byte.
BUSY  output  1  high while a frame is in progress.
DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, while RST_N=0): SCLK=0, MOSI=0, SS_N=1, BUSY=0, DONE=0, RX_DATA=0, FSM=IDLE, divider and edge counters cleared. Reset mid-frame aborts the frame immediately. RX_DATA returns to 0 and no DONE is produced.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - SS_N=1, BUSY=0, MOSI=0.
  - SCLK is registered from the CPOL input every cycle.
  - START=1 at a posedge: latch TX_DATA, CPOL and CPHA; set BUSY=1 and SS_N=0 on that edge; go to SETUP.
- SETUP (DIV cycles):
  - CPHA=0: MOSI = TX MSB from SS_N fall.
  - CPHA=1: MOSI is held at 0 until the first edge.
- SHIFT:
  - 2*DATA_W SCLK edges. Edge n (n=1..16) occurs exactly n*DIV cycles after SS_N falls. Each edge toggles SCLK.
  - CPHA=0: odd edges sample MISO into the receive shift register, MSB first; even edges 2..14 shift the next TX bit onto MOSI; edge 16 does not change MOSI.
  - CPHA=1: odd edges drive the next TX bit (edge 1 drives the MSB); even edges sample MISO.
  - MISO is sampled on the same CLK posedge on which SCLK toggles.
- HOLD (DIV cycles after edge 16):
  - SCLK is at its idle level and SS_N stays 0.
  - At the end of HOLD (17*DIV cycles after SS_N falls), in the same posedge: SS_N=1, BUSY=0, DONE=1 for one cycle, RX_DATA = received byte, FSM=IDLE.
- START handling:
  - START while BUSY is ignored; it is not queued.
  - START high in the cycle DONE is high is accepted, giving back-to-back frames with SS_N high for exactly 1 cycle.
- Mode inputs: CPOL, CPHA and TX_DATA changes while BUSY have no effect on the current frame.
- Frame length: exactly 8 SCLK rising and 8 falling edges per frame in all modes.
- DIV=1: SCLK half-period is 1 CLK; all timing formulas hold unchanged.
- RX_DATA changes only at DONE.

Test Plan:
1. DIV=2, mode 0, MOSI looped to MISO, TX=0xA5, START pulse → SS_N low 1 cycle after START; 8 rising SCLK edges; DONE 34 cycles after SS_N fall; RX_DATA=0xA5.
2. DIV=3, mode 3 (CPOL=1, CPHA=1), slave model returns 0x3C on falling edges and checks MOSI on rising edges, TX=0xC3 → SCLK idles high before and after the frame; slave receives 0xC3; RX_DATA=0x3C; DONE 51 cycles after SS_N fall.
3. Modes 1 and 2 with DIV=1, TX=0x81, loopback → RX_DATA=0x81; DONE 17 cycles after SS_N fall.
4. Second START and TX_DATA=0xFF applied mid-frame of a 0x12 transfer → ignored; single DONE; MOSI carries 0x12; BUSY never drops mid-frame.
5. START held high across DONE with two queued bytes 0x55, 0xAA → SS_N high exactly 1 cycle between frames; RX_DATA=0x55, then 0xAA.
6. RST_N pulsed low at edge 7 of a frame → SS_N=1, SCLK=0, BUSY=0, RX_DATA=0 immediately; no DONE; next START runs a clean frame.
